mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between a core's load/store stage and mem_access_unit.
// The core side takes the master modport; the memory unit takes the slave modport.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic [1:0]  err_code;

    modport master (
        output req_valid, we, func3, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, err_code
    );

    modport slave (
        input  req_valid, we, func3, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, err_code
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-port 32-bit data RAM with RISC-V style byte/half/word loads and stores.
// Each request is checked for errors, and its response is held until the consumer takes it.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic [1:0]        err_d;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;
    logic [31:0]       wrep;

    logic              we_q;
    logic [2:0]        func3_q;
    logic [1:0]        off_q;
    logic [1:0]        err_q;
    logic [31:0]       rd_q;

    logic [31:0]       mem_q [2**ADDR_W];

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign accept = bus.req_valid && (state_q == StIdle);
    assign idx    = bus.addr[ADDR_W+1:2];

    always_comb begin
        illegal = 1'b1;
        case (bus.func3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.we;
            default:                illegal = 1'b1;
        endcase
    end

    // func3[1:0] == 01 covers both H and HU.
    assign misaligned = ((bus.func3[1:0] == 2'b01) && bus.addr[0]) ||
                        ((bus.func3 == 3'b010) && (bus.addr[1:0] != 2'b00));

    always_comb begin
        err_d = 2'b00;
        if (illegal) begin
            err_d = 2'b11;
        end else if (misaligned) begin
            err_d = 2'b01;
        end else if (|bus.addr[31:ADDR_W+2]) begin
            err_d = 2'b10;
        end
    end

    always_comb begin
        be   = 4'b0000;
        wrep = bus.wdata;
        case (bus.func3[1:0])
            2'b00: begin
                be   = 4'b0001 << bus.addr[1:0];
                wrep = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{bus.wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StResp;
            StResp: if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            func3_q <= 3'b000;
            off_q   <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.we;
                func3_q <= bus.func3;
                off_q   <= bus.addr[1:0];
                err_q   <= err_d;
            end
        end
    end

    // RAM array and its read register carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q <= mem_q[idx];
            if (bus.we && (err_d == 2'b00)) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem_q[idx][i*8 +: 8] <= wrep[i*8 +: 8];
                end
            end
        end
    end

    assign byte_sel = rd_q[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? rd_q[31:16] : rd_q[15:0];

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.err_code  = bus.rsp_valid ? err_q : 2'b00;

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.rsp_valid && !we_q && (err_q == 2'b00)) begin
            case (func3_q)
                3'b000:  bus.rdata = {{24{byte_sel[7]}}, byte_sel};
                3'b001:  bus.rdata = {{16{half_sel[15]}}, half_sel};
                3'b010:  bus.rdata = rd_q;
                3'b100:  bus.rdata = {24'h0, byte_sel};
                3'b101:  bus.rdata = {16'h0, half_sel};
                default: bus.rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each scenario task drives requests and checks
// responses inline against hand-computed values.
module tb_mem_access_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_access_unit_if m ();

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Single request with rsp_ready=1: returns request-accepted flag, response one cycle after
    // accept, and rsp_valid after the following edge.
    task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic rdy, output logic vld,
                        output logic [31:0] rd, output logic [1:0] ec, output logic vld_after);
        @(negedge clk);
        m.req_valid = 1'b1;
        m.we        = w;
        m.func3     = f3;
        m.addr      = a;
        m.wdata     = wd;
        m.rsp_ready = 1'b1;
        rdy = m.req_ready;
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        vld = m.rsp_valid;
        rd  = m.rdata;
        ec  = m.err_code;
        @(posedge clk);
        #1;
        vld_after = m.rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_rsp_valid got=%b exp=0", m.rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (m.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", m.req_ready); end
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", m.rsp_valid); end
        total++; if (m.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", m.rdata); end
        total++; if (m.err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code got=%b exp=00", m.err_code); end
    endtask

    task automatic test_store_load();
        logic rdy, vld, va;
        logic [31:0] rd;
        logic [1:0] ec;
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rdy, vld, rd, ec, va);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", rdy); end
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL sw_latency got=%b exp=1", vld); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h exp=00000000", rd); end
        total++; if (ec !== 2'b00) begin bad++; $display("FAIL sw_err got=%b exp=00", ec); end
        total++; if (va !== 1'b0) begin bad++; $display("FAIL sw_release got=%b exp=0", va); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, rdy, vld, rd, ec, va);
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL lw_latency got=%b exp=1", vld); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
        total++; if (ec !== 2'b00) begin bad++; $display("FAIL lw_err got=%b exp=00", ec); end
    endtask

    task automatic test_sub_word();
        logic rdy, vld, va;
        logic [31:0] rd;
        logic [1:0] ec;
        xact(1'b1, 3'b000, 32'h13, 32'h00000080, rdy, vld, rd, ec, va);
        xact(1'b0, 3'b000, 32'h13, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_13 got=%h exp=ffffff80", rd); end
        xact(1'b0, 3'b100, 32'h13, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu_13 got=%h exp=00000080", rd); end
        xact(1'b0, 3'b010, 32'h10, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_10_after_sb got=%h exp=80adbeef", rd); end
        xact(1'b0, 3'b001, 32'h12, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'hFFFF80AD) begin bad++; $display("FAIL lh_12 got=%h exp=ffff80ad", rd); end
        xact(1'b0, 3'b101, 32'h12, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'h000080AD) begin bad++; $display("FAIL lhu_12 got=%h exp=000080ad", rd); end
        xact(1'b0, 3'b000, 32'h11, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb_11 got=%h exp=ffffffbe", rd); end
        xact(1'b1, 3'b010, 32'h14, 32'h11223344, rdy, vld, rd, ec, va);
        xact(1'b1, 3'b001, 32'h16, 32'h1234ABCD, rdy, vld, rd, ec, va);
        xact(1'b0, 3'b010, 32'h14, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'hABCD3344) begin bad++; $display("FAIL sh_16_word got=%h exp=abcd3344", rd); end
        xact(1'b0, 3'b001, 32'h14, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'h00003344) begin bad++; $display("FAIL lh_14 got=%h exp=00003344", rd); end
    endtask

    task automatic test_errors();
        logic rdy, vld, va;
        logic [31:0] rd;
        logic [1:0] ec;
        xact(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, rdy, vld, rd, ec, va);
        xact(1'b0, 3'b001, 32'h11, 32'h0, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b01) begin bad++; $display("FAIL lh_11_err got=%b exp=01", ec); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL lh_11_rdata got=%h exp=00000000", rd); end
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL lh_11_valid got=%b exp=1", vld); end
        xact(1'b1, 3'b010, 32'h400, 32'h1, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b10) begin bad++; $display("FAIL sw_400_err got=%b exp=10", ec); end
        xact(1'b1, 3'b010, 32'h2, 32'h55555555, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b01) begin bad++; $display("FAIL sw_2_err got=%b exp=01", ec); end
        xact(1'b1, 3'b100, 32'h0, 32'h77, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b11) begin bad++; $display("FAIL sbu_err got=%b exp=11", ec); end
        xact(1'b0, 3'b010, 32'h0, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL lw_0_unchanged got=%h exp=cafef00d", rd); end
        total++; if (ec !== 2'b00) begin bad++; $display("FAIL lw_0_err got=%b exp=00", ec); end
        xact(1'b0, 3'b110, 32'h10, 32'h0, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b11) begin bad++; $display("FAIL f3_110_err got=%b exp=11", ec); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL f3_110_rdata got=%h exp=00000000", rd); end
        // Illegal func3 outranks misalignment and range.
        xact(1'b0, 3'b011, 32'h1001, 32'h0, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b11) begin bad++; $display("FAIL f3_011_prio got=%b exp=11", ec); end
        xact(1'b0, 3'b010, 32'h1002, 32'h0, rdy, vld, rd, ec, va);
        total++; if (ec !== 2'b01) begin bad++; $display("FAIL misalign_prio got=%b exp=01", ec); end
        #1;
        total++; if (m.err_code !== 2'b00) begin bad++; $display("FAIL idle_err_code got=%b exp=00", m.err_code); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        m.req_valid = 1'b1;
        m.we        = 1'b0;
        m.func3     = 3'b010;
        m.addr      = 32'h10;
        m.wdata     = 32'h0;
        m.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        total++; if (m.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_latency got=%b exp=1", m.rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (m.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, m.rsp_valid); end
            total++; if (m.rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL bp_hold_rdata[%0d] got=%h exp=80adbeef", i, m.rdata); end
            total++; if (m.req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, m.req_ready); end
        end
        @(negedge clk);
        m.rsp_ready = 1'b1;
        m.addr      = 32'h14;
        @(posedge clk);
        #1;
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", m.rsp_valid); end
        total++; if (m.req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready got=%b exp=1", m.req_ready); end
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        total++; if (m.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_next_accept got=%b exp=1", m.rsp_valid); end
        total++; if (m.rdata !== 32'hABCD3344) begin bad++; $display("FAIL bp_next_rdata got=%h exp=abcd3344", m.rdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_resp();
        logic rdy, vld, va;
        logic [31:0] rd;
        logic [1:0] ec;
        @(negedge clk);
        m.req_valid = 1'b1;
        m.we        = 1'b1;
        m.func3     = 3'b010;
        m.addr      = 32'h20;
        m.wdata     = 32'h12345678;
        m.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        m.req_valid = 1'b0;
        total++; if (m.rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_sw_valid got=%b exp=1", m.rsp_valid); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (m.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", m.rsp_valid); end
        total++; if (m.req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", m.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 3'b010, 32'h20, 32'h0, rdy, vld, rd, ec, va);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL lw_20_after_rst got=%h exp=12345678", rd); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        m.req_valid = 1'b0;
        m.we        = 1'b0;
        m.func3     = 3'b000;
        m.addr      = 32'h0;
        m.wdata     = 32'h0;
        m.rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_sub_word();
        test_errors();
        test_backpressure();
        test_reset_mid_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
